mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 145 ++++++++++++++
 tb/tb_mult_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Shares one fully pipelined signed multiplier among N_REQ
//               requesters. A combinational round-robin arbiter grants at
//               most one requester per cycle. The granted operands are
//               registered onto the multiplier inputs. A tag pipeline follows
//               each operation so its product can be routed back as a
//               one-hot result strobe on a shared result bus.
// Ports       : clk_i, rst_i          - clock, async active-high reset
//               req_mask_i            - per-requester enable
//               req_valid_i           - per-requester operand valid
//               req_ready_o           - per-requester grant (one-hot or 0)
//               req_a_i / req_b_i     - packed operands, requester i at slice i
//               res_valid_o / res_o   - one-hot result strobe, shared result
//               mul_a_o / mul_b_o     - operands to the external multiplier
//               mul_res_i             - product, MUL_LATENCY cycles later
//               busy_o                - any operation issued or in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
  parameter int N_REQ       = 4,
  parameter int A_WIDTH     = 25,
  parameter int B_WIDTH     = 18,
  parameter int R_WIDTH     = A_WIDTH + B_WIDTH,
  parameter int MUL_LATENCY = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_mask_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*A_WIDTH-1:0] req_a_i,
  input  logic [N_REQ*B_WIDTH-1:0] req_b_i,
  output logic [N_REQ-1:0]         res_valid_o,
  output logic [R_WIDTH-1:0]       res_o,
  output logic [A_WIDTH-1:0]       mul_a_o,
  output logic [B_WIDTH-1:0]       mul_b_o,
  input  logic [R_WIDTH-1:0]       mul_res_i,
  output logic                     busy_o
);

  localparam int C_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Reset the pointer to the last requester so requester 0 is searched first.
  localparam logic [C_IDX_W-1:0] C_PTR_RST = C_IDX_W'(N_REQ - 1);

  // Arbitration
  logic [N_REQ-1:0]   w_eligible;
  logic [N_REQ-1:0]   w_ready;
  logic [C_IDX_W-1:0] w_cand;
  logic [C_IDX_W-1:0] w_grant_idx;
  logic               w_found;
  logic               w_handshake;

  // Registers
  logic [C_IDX_W-1:0] ptr_q, ptr_d;
  logic [A_WIDTH-1:0] mul_a_q, mul_a_d;
  logic [B_WIDTH-1:0] mul_b_q, mul_b_d;
  // Stage 0 travels with the registered operands; stage MUL_LATENCY lines up
  // with the product on mul_res_i.
  logic [MUL_LATENCY:0]              tag_v_q, tag_v_d;
  logic [MUL_LATENCY:0][C_IDX_W-1:0] tag_idx_q, tag_idx_d;
  logic [N_REQ-1:0]   res_valid_q, res_valid_d;
  logic [R_WIDTH-1:0] res_q, res_d;

  assign w_eligible = req_valid_i & req_mask_i;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = C_IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!w_found && w_eligible[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // Grants are suppressed while reset is held, independent of the clock.
  assign w_ready     = (w_found && !rst_i) ? (N_REQ'(1) << w_grant_idx) : '0;
  assign w_handshake = |(w_ready & req_valid_i);

  // Next-state: pointer, operand mux and tag shift.
  always_comb begin
    ptr_d   = w_handshake ? w_grant_idx : ptr_q;
    mul_a_d = '0;
    mul_b_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_ready[i]) begin
        mul_a_d = req_a_i[i*A_WIDTH +: A_WIDTH];
        mul_b_d = req_b_i[i*B_WIDTH +: B_WIDTH];
      end
    end
    tag_v_d      = '0;
    tag_idx_d    = '0;
    tag_v_d[0]   = w_handshake;
    tag_idx_d[0] = w_grant_idx;
    for (int s = 1; s <= MUL_LATENCY; s++) begin
      tag_v_d[s]   = tag_v_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  // Result capture: res_o keeps its last product when nothing returns.
  always_comb begin
    res_valid_d = '0;
    res_d       = res_q;
    if (tag_v_q[MUL_LATENCY]) begin
      res_valid_d = N_REQ'(1) << tag_idx_q[MUL_LATENCY];
      res_d       = mul_res_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= C_PTR_RST;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_v_q     <= '0;
      tag_idx_q   <= '0;
      res_valid_q <= '0;
      res_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_v_q     <= tag_v_d;
      tag_idx_q   <= tag_idx_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign req_ready_o = w_ready;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;
  assign busy_o      = |tag_v_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Directed self-checking bench for mult_arbiter with a
//               two-stage signed multiplier model on the multiplier ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int AW = 25;
  localparam int BW = 18;
  localparam int RW = 43;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_mask  = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]    res_valid;
  logic [RW-1:0]   res_o;
  logic [AW-1:0]   mul_a;
  logic [BW-1:0]   mul_b;
  logic [RW-1:0]   mul_res;
  logic            busy;

  logic signed [AW-1:0] a_arr [N];
  logic signed [BW-1:0] b_arr [N];
  logic signed [RW-1:0] p1 = '0;
  logic signed [RW-1:0] p2 = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = a_arr[i];
      req_b[i*BW +: BW] = b_arr[i];
    end
  end

  // Multiplier model: product appears two cycles after operands.
  always @(posedge clk) begin
    p1 <= $signed(mul_a) * $signed(mul_b);
    p2 <= p1;
  end
  assign mul_res = p2;

  mult_arbiter #(
    .N_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .R_WIDTH(RW), .MUL_LATENCY(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_mask_i(req_mask), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .req_a_i(req_a), .req_b_i(req_b),
    .res_valid_o(res_valid), .res_o(res_o), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_res_i(mul_res), .busy_o(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_mask  = 4'hF;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_mask  = 4'hF;
    req_valid = 4'hF;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    tick();
    tick();
    total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL reset_res_valid: got %b want 0000", res_valid); end
    total++; if (res_o !== '0) begin bad++; $display("FAIL reset_res: got %h want 0", res_o); end
    total++; if (mul_a !== '0 || mul_b !== '0) begin bad++; $display("FAIL reset_mul_ops: got %h/%h want 0/0", mul_a, mul_b); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_held: got %b want 0000", req_ready); end
    req_valid = '0;
    rst       = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] exp_rv;
    do_reset();
    req_mask  = 4'hF;
    req_valid = 4'b0100;
    a_arr[2]  = 25'sd3;
    b_arr[2]  = -18'sd5;
    #4;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    total++; if ($signed(mul_a) !== 25'sd3 || $signed(mul_b) !== -18'sd5) begin bad++; $display("FAIL single_issue: got %h/%h want 3/-5", mul_a, mul_b); end
    for (int k = 1; k <= 5; k++) begin
      exp_rv = (k == 4) ? 4'b0100 : 4'b0000;
      total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL single_res_valid k=%0d: got %b want %b", k, res_valid, exp_rv); end
      if (k >= 4) begin
        total++; if ($signed(res_o) !== -43'sd15) begin bad++; $display("FAIL single_res k=%0d: got %0d want -15", k, $signed(res_o)); end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic signed [RW-1:0] prod [N];
    logic [3:0] exp_rv;
    logic [3:0] exp_rdy;
    a_arr = '{25'sd100, -25'sd200, 25'sd300, -25'sd400};
    b_arr = '{18'sd5, 18'sd6, -18'sd7, 18'sd8};
    prod  = '{43'sd500, -43'sd1200, -43'sd2100, -43'sd3200};
    do_reset();
    for (int m = 0; m < 12; m++) begin
      exp_rv = (m >= 4) ? 4'(1 << ((m - 4) % 4)) : 4'b0000;
      total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL fair_res_valid m=%0d: got %b want %b", m, res_valid, exp_rv); end
      if (m >= 4) begin
        total++; if ($signed(res_o) !== prod[(m - 4) % 4]) begin bad++; $display("FAIL fair_res m=%0d: got %0d want %0d", m, $signed(res_o), prod[(m - 4) % 4]); end
      end
      req_valid = (m < 8) ? 4'hF : 4'h0;
      #4;
      exp_rdy = (m < 8) ? 4'(1 << (m % 4)) : 4'b0000;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL fair_ready m=%0d: got %b want %b", m, req_ready, exp_rdy); end
      if (m == 0) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_busy_idle: got %b want 0", busy); end
      end else if (m <= 10) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fair_busy m=%0d: got %b want 1", m, busy); end
      end
      tick();
    end
    total++; if (busy !== 1'b0 || res_valid !== 4'b0000) begin bad++; $display("FAIL fair_drain: got busy=%b rv=%b want 0/0000", busy, res_valid); end
    tick();
  endtask

  task automatic test_mask();
    logic [3:0] mask_tab [10] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000,
                                  4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [3:0] vld_tab  [10] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                  4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] rdy_tab  [10] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000,
                                  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] rv_tab   [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
                                  4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0001};
    logic signed [RW-1:0] res_tab [10] = '{43'sd0, 43'sd0, 43'sd0, 43'sd0, -43'sd1200,
                                           -43'sd3200, -43'sd1200, -43'sd3200, 43'sd0, 43'sd500};
    for (int c = 0; c < 10; c++) begin
      total++; if (res_valid !== rv_tab[c]) begin bad++; $display("FAIL mask_res_valid c=%0d: got %b want %b", c, res_valid, rv_tab[c]); end
      if (rv_tab[c] != 4'b0000) begin
        total++; if ($signed(res_o) !== res_tab[c]) begin bad++; $display("FAIL mask_res c=%0d: got %0d want %0d", c, $signed(res_o), res_tab[c]); end
      end
      req_mask  = mask_tab[c];
      req_valid = vld_tab[c];
      #4;
      total++; if (req_ready !== rdy_tab[c]) begin bad++; $display("FAIL mask_ready c=%0d: got %b want %b", c, req_ready, rdy_tab[c]); end
      tick();
    end
    req_mask = 4'hF;
  endtask

  task automatic test_extremes();
    logic [3:0] exp_rv;
    logic signed [RW-1:0] exp_res [2] = '{43'h200_0000_0000, 43'h600_0002_0000};
    req_mask  = 4'hF;
    req_valid = 4'b0001;
    a_arr[0]  = 25'h1000000;
    b_arr[0]  = 18'h20000;
    #4;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL ext_ready0: got %b want 0001", req_ready); end
    tick();
    a_arr[0] = 25'h0FFFFFF;
    #4;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL ext_ready1: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 2; k <= 5; k++) begin
      exp_rv = (k >= 4) ? 4'b0001 : 4'b0000;
      total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL ext_res_valid k=%0d: got %b want %b", k, res_valid, exp_rv); end
      if (k >= 4) begin
        total++; if (res_o !== exp_res[k - 4]) begin bad++; $display("FAIL ext_res k=%0d: got %h want %h", k, res_o, exp_res[k - 4]); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] exp_rv;
    a_arr[0] = 25'sd100;
    b_arr[0] = 18'sd5;
    req_mask = 4'hF;
    for (int s = 0; s < 3; s++) begin
      req_valid = 4'hF;
      #4;
      total++; if (req_ready !== 4'(2 << s)) begin bad++; $display("FAIL rmf_issue s=%0d: got %b want %b", s, req_ready, 4'(2 << s)); end
      tick();
    end
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000 || res_valid !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rmf_in_reset_ctl: got rdy=%b rv=%b busy=%b want 0000/0000/0", req_ready, res_valid, busy); end
    total++; if (mul_a !== '0 || mul_b !== '0 || res_o !== '0) begin bad++; $display("FAIL rmf_in_reset_data: got %h/%h/%h want 0/0/0", mul_a, mul_b, res_o); end
    tick();
    rst = 1'b0;
    total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL rmf_stale k=4: got %b want 0000", res_valid); end
    #4;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmf_ptr_restart: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 5; k <= 12; k++) begin
      exp_rv = (k == 8) ? 4'b0001 : 4'b0000;
      total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL rmf_res_valid k=%0d: got %b want %b", k, res_valid, exp_rv); end
      if (k == 5) begin
        total++; if (res_o !== '0) begin bad++; $display("FAIL rmf_res_hold: got %h want 0", res_o); end
      end
      if (k == 8) begin
        total++; if ($signed(res_o) !== 43'sd500) begin bad++; $display("FAIL rmf_res: got %0d want 500", $signed(res_o)); end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_mask();
    test_extremes();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
